// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: geometry, byte-enable codes, trace record layout.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package dm_responder_pkg;

  localparam int DM_WORDS_DEF    = 3072;
  localparam int TRACE_DEPTH_DEF = 8;

  // Word index is taken from fixed address bits regardless of DM_WORDS.
  localparam int IDX_LSB = 2;
  localparam int IDX_MSB = 13;
  localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

  // Trace record field widths.
  localparam int PC_W   = 32;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REC_W  = PC_W + ADDR_W + DATA_W;

  // Legal byte-enable patterns issued by the CPU.
  typedef enum logic [3:0] {
    BE_NONE    = 4'b0000,
    BE_BYTE0   = 4'b0001,
    BE_BYTE1   = 4'b0010,
    BE_BYTE2   = 4'b0100,
    BE_BYTE3   = 4'b1000,
    BE_HALF_LO = 4'b0011,
    BE_HALF_HI = 4'b1100,
    BE_WORD    = 4'b1111
  } byteen_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_rec_t;

  // Overlay the enabled byte lanes of wdata onto the old word.
  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [3:0]        byteen);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_responder_trace_fifo.sv
// Store-trace FIFO: circular buffer of trace records with an occupancy counter.
// Latency: a pushed record is visible at pop_data one cycle after the push edge.
// Backpressure: push when full is accepted only if a pop happens on the same edge; pop on empty is ignored.
module trace_fifo
  import dm_responder_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  trace_rec_t                push_data,
  input  logic                      pop,
  output trace_rec_t                pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [REC_W-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = trace_rec_t'(store[rd_ptr]);

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Record storage needs no reset: only entries between the pointers are ever read as valid.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: byte-lane RAM with combinational read, store tracing and error flags.
// Latency: read 0 cycles; store lands and its trace record appears one cycle after the store edge.
// Backpressure: trace records wait for trace_ready; a record arriving with the FIFO full and no pop is dropped.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DM_WORDS    = DM_WORDS_DEF,
  parameter int TRACE_DEPTH = TRACE_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_overflow,
  output logic        oor_err,
  output logic [15:0] store_count
);

  logic [31:0]                  mem [DM_WORDS];
  logic [IDX_W-1:0]             idx;
  logic                         in_range;
  logic                         is_store;
  logic                         store_ok;
  logic [31:0]                  merged;
  trace_rec_t                   rec_in;
  trace_rec_t                   rec_head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(TRACE_DEPTH):0] fifo_count;
  logic                         pop;

  assign idx          = m_data_addr[IDX_MSB:IDX_LSB];
  assign in_range     = m_data_addr < 32'(4 * DM_WORDS);
  assign is_store     = (m_data_byteen != BE_NONE);
  assign store_ok     = is_store && in_range;
  assign m_data_rdata = in_range ? mem[idx] : 32'h0;
  assign merged       = merge_word(m_data_rdata, m_data_wdata, m_data_byteen);

  assign rec_in.pc   = m_inst_addr;
  assign rec_in.addr = {m_data_addr[31:2], 2'b00};
  assign rec_in.data = merged;

  assign trace_valid = (fifo_count != '0);
  assign pop         = trace_ready && !fifo_empty;
  assign trace_pc    = rec_head.pc;
  assign trace_addr  = rec_head.addr;
  assign trace_data  = rec_head.data;

  // Memory array: cleared on reset, enabled lanes merged on in-range stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= 32'h0;
    end else if (store_ok) begin
      mem[idx] <= merged;
    end
  end

  // Store counter and sticky error flags. A plain read only flags when the
  // upper address bits are set; reads that merely overrun DM_WORDS are tolerated.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_count    <= 16'h0;
      oor_err        <= 1'b0;
      trace_overflow <= 1'b0;
    end else begin
      if (store_ok) store_count <= store_count + 16'h1;
      if ((is_store && !in_range) || (!is_store && (m_data_addr[31:14] != '0)))
        oor_err <= 1'b1;
      if (store_ok && fifo_full && !pop)
        trace_overflow <= 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (store_ok),
    .push_data (rec_in),
    .pop       (pop),
    .pop_data  (rec_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a vector table for read/store behaviour plus
// hand sequences for trace FIFO overflow, full push+pop, and mid-stream reset.
module tb_dm_responder;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;
  logic        oor_err;
  logic [15:0] store_count;

  int checks;
  int failures;

  dm_responder dut (
    .clk            (clk),
    .reset          (reset),
    .m_data_addr    (m_data_addr),
    .m_data_wdata   (m_data_wdata),
    .m_data_byteen  (m_data_byteen),
    .m_inst_addr    (m_inst_addr),
    .m_data_rdata   (m_data_rdata),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow),
    .oor_err        (oor_err),
    .store_count    (store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
    logic [31:0] pre;    // rdata seen in the store cycle (old word)
    logic [31:0] post;   // rdata at the same address after the edge
    logic        oor;
    logic [15:0] cnt;
    logic        push;   // record expected at trace head after the edge
    logic [31:0] taddr;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_data_byteen = 4'h0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] pc);
    m_data_addr   = addr;
    m_data_wdata  = wdata;
    m_data_byteen = be;
    m_inst_addr   = pc;
    tick();
    m_data_byteen = 4'h0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    m_data_addr = 32'h0;
    m_data_wdata = 32'h0;
    m_data_byteen = 4'h0;
    m_inst_addr = 32'h0;
    trace_ready = 1'b1;

    //        addr          wdata         be       pc            pre           post          oor   cnt  push  taddr
    vt[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_3000, 32'h0,        32'hDEAD_BEEF, 1'b0, 16'd1, 1'b1, 32'h10};
    vt[1] = '{32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0000_3004, 32'h0,        32'h1122_3344, 1'b0, 16'd2, 1'b1, 32'h20};
    vt[2] = '{32'h0000_0020, 32'h0000_AB00, 4'b0010, 32'h0000_3008, 32'h1122_3344, 32'h1122_AB44, 1'b0, 16'd3, 1'b1, 32'h20};
    vt[3] = '{32'h0000_0022, 32'h5500_0000, 4'b1000, 32'h0000_300C, 32'h1122_AB44, 32'h5522_AB44, 1'b0, 16'd4, 1'b1, 32'h20};
    vt[4] = '{32'h0000_0010, 32'h0000_CAFE, 4'b0011, 32'h0000_3010, 32'hDEAD_BEEF, 32'hDEAD_CAFE, 1'b0, 16'd5, 1'b1, 32'h10};
    vt[5] = '{32'h0000_2FFC, 32'hA5A5_0000, 4'b1100, 32'h0000_3014, 32'h0,        32'hA5A5_0000, 1'b0, 16'd6, 1'b1, 32'h2FFC};
    vt[6] = '{32'h0000_3000, 32'h0,         4'b0000, 32'h0000_3018, 32'h0,        32'h0,         1'b0, 16'd6, 1'b0, 32'h0};
    vt[7] = '{32'h0000_3000, 32'h1234_5678, 4'b1111, 32'h0000_301C, 32'h0,        32'h0,         1'b1, 16'd6, 1'b0, 32'h0};
    vt[8] = '{32'h0000_0000, 32'h0,         4'b0000, 32'h0000_3020, 32'h0,        32'h0,         1'b1, 16'd6, 1'b0, 32'h0};
    vt[9] = '{32'h0000_0013, 32'h0000_00EE, 4'b0001, 32'h0000_3024, 32'hDEAD_CAFE, 32'hDEAD_CAEE, 1'b1, 16'd7, 1'b1, 32'h10};

    // Reset state
    tick();
    do_reset();
    m_data_addr = 32'h10;
    #1;
    chk("rst_rdata", m_data_rdata, 32'h0);
    chk("rst_valid", {31'h0, trace_valid}, 32'h0);
    chk("rst_ovf", {31'h0, trace_overflow}, 32'h0);
    chk("rst_oor", {31'h0, oor_err}, 32'h0);
    chk("rst_cnt", {16'h0, store_count}, 32'h0);

    // Table: trace_ready held high, so each record is popped on the next edge.
    for (int i = 0; i < 10; i++) begin
      m_data_addr   = vt[i].addr;
      m_data_wdata  = vt[i].wdata;
      m_data_byteen = vt[i].be;
      m_inst_addr   = vt[i].pc;
      #1;
      chk($sformatf("v%0d_pre", i), m_data_rdata, vt[i].pre);
      tick();
      m_data_byteen = 4'h0;
      #1;
      chk($sformatf("v%0d_post", i), m_data_rdata, vt[i].post);
      chk($sformatf("v%0d_oor", i), {31'h0, oor_err}, {31'h0, vt[i].oor});
      chk($sformatf("v%0d_cnt", i), {16'h0, store_count}, {16'h0, vt[i].cnt});
      chk($sformatf("v%0d_tv", i), {31'h0, trace_valid}, {31'h0, vt[i].push});
      if (vt[i].push) begin
        chk($sformatf("v%0d_tpc", i), trace_pc, vt[i].pc);
        chk($sformatf("v%0d_taddr", i), trace_addr, vt[i].taddr);
        chk($sformatf("v%0d_tdata", i), trace_data, vt[i].post);
      end
    end
    m_data_addr = 32'h3000;
    #1;
    chk("oor_store_rdata", m_data_rdata, 32'h0);

    // Plain read with high address bits set flags oor_err
    do_reset();
    m_data_addr = 32'h0001_0000;
    tick();
    chk("oor_hi_read", {31'h0, oor_err}, 32'h1);
    do_reset();
    m_data_addr = 32'h0000_3FFC;
    tick();
    chk("oor_lo_read", {31'h0, oor_err}, 32'h0);

    // Overflow: 9 stores with no consumer
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      do_store(32'(4*i), 32'h100 + 32'(i), 4'b1111, 32'h4000 + 32'(4*i));
    chk("ovf_flag", {31'h0, trace_overflow}, 32'h1);
    chk("ovf_cnt", {16'h0, store_count}, 32'd9);
    m_data_addr = 32'h20;
    #1;
    chk("ovf_mem8", m_data_rdata, 32'h108);
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_tv%0d", i), {31'h0, trace_valid}, 32'h1);
      chk($sformatf("ovf_pc%0d", i), trace_pc, 32'h4000 + 32'(4*i));
      chk($sformatf("ovf_data%0d", i), trace_data, 32'h100 + 32'(i));
      tick();
    end
    chk("ovf_drained", {31'h0, trace_valid}, 32'h0);
    chk("ovf_sticky", {31'h0, trace_overflow}, 32'h1);

    // Full FIFO with push and pop on the same edge
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      do_store(32'h40 + 32'(4*i), 32'h200 + 32'(i), 4'b1111, 32'h5000 + 32'(4*i));
    chk("full_noovf", {31'h0, trace_overflow}, 32'h0);
    trace_ready = 1'b1;
    do_store(32'h60, 32'h208, 4'b1111, 32'h5020);
    chk("fullpp_noovf", {31'h0, trace_overflow}, 32'h0);
    for (int i = 1; i < 9; i++) begin
      chk($sformatf("fullpp_tv%0d", i), {31'h0, trace_valid}, 32'h1);
      chk($sformatf("fullpp_data%0d", i), trace_data, 32'h200 + 32'(i));
      tick();
    end
    chk("fullpp_drained", {31'h0, trace_valid}, 32'h0);

    // Reset with records pending; a store during reset is ignored
    trace_ready = 1'b0;
    do_store(32'h10, 32'hAAAA_0001, 4'b1111, 32'h6000);
    do_store(32'h14, 32'hAAAA_0002, 4'b1111, 32'h6004);
    do_store(32'h18, 32'hAAAA_0003, 4'b1111, 32'h6008);
    chk("pend_tv", {31'h0, trace_valid}, 32'h1);
    reset = 1'b1;
    m_data_addr = 32'h10;
    m_data_wdata = 32'hFFFF_FFFF;
    m_data_byteen = 4'b1111;
    tick();
    reset = 1'b0;
    m_data_byteen = 4'h0;
    #1;
    chk("mid_rst_tv", {31'h0, trace_valid}, 32'h0);
    chk("mid_rst_cnt", {16'h0, store_count}, 32'h0);
    chk("mid_rst_rdata", m_data_rdata, 32'h0);
    tick();
    chk("mid_rst_idle_tv", {31'h0, trace_valid}, 32'h0);
    chk("mid_rst_idle_rdata", m_data_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DM_WORDS, default 3072, number of 32-bit data words (byte range 0x0000-0x2FFF).
REQ-002 Parameter TRACE_DEPTH, default 8, store-trace FIFO depth in entries; power of two.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 m_data_addr  input  32  CPU data byte address.
REQ-006 m_data_wdata  input  32  CPU store data, lane-aligned.
REQ-007 m_data_byteen  input  4  byte-lane write enables; bit i selects bits [8i+7:8i]; 0000 = no store.
REQ-008 m_inst_addr  input  32  PC of the instruction issuing the access.
REQ-009 m_data_rdata  output  32  read data word.
REQ-010 trace_valid  output  1  trace record available.
REQ-011 trace_ready  input  1  consumer accepts record.
REQ-012 trace_pc / trace_addr / trace_data  output  32 each  record: PC, word-aligned address, full merged word after the store.
REQ-013 trace_overflow  output  1  sticky: a record was dropped.
REQ-014 oor_err  output  1  sticky: out-of-range access seen.
REQ-015 store_count  output  16  accepted in-range stores since reset.

Function
REQ-016 Word index SHALL be m_data_addr[13:2]; addr[1:0] ignored for indexing.
REQ-017 In range SHALL mean m_data_addr < 4*DM_WORDS.
REQ-018 m_data_rdata SHALL be combinational: mem[index] if in range, else 0.
REQ-019 A store (byteen != 0, in range) SHALL update only enabled lanes at the next edge.
REQ-020 Reads in the same cycle as a store SHALL return the pre-store word (no write-through).
REQ-021 Out-of-range store SHALL leave memory unchanged, push no record, and set oor_err.
REQ-022 Out-of-range read with byteen = 0 SHALL set oor_err only when byteen = 0 and addr differs from 0 in bits [31:14]. Otherwise it SHALL leave oor_err unchanged.
REQ-023 Each in-range store SHALL push one record {m_inst_addr, addr & ~3, merged word} at the same edge and increment store_count (wraps 0xFFFF->0).
REQ-024 trace_valid SHALL equal FIFO not empty; the head record is held stable while trace_valid && !trace_ready.
REQ-025 A pop SHALL occur on an edge where trace_valid && trace_ready.
REQ-026 Push with FIFO full and no pop SHALL drop the new record, keep the FIFO contents, and set trace_overflow.
REQ-027 Simultaneous push and pop when full SHALL succeed: the occupancy stays at TRACE_DEPTH and no overflow occurs.
REQ-028 Simultaneous push and pop when empty SHALL NOT pop; after the edge the occupancy SHALL be 1.
REQ-029 FIFO pointers SHALL wrap modulo TRACE_DEPTH; an occupancy counter of log2(TRACE_DEPTH)+1 bits SHALL distinguish full from empty.
REQ-030 Latency: record visible at trace_* one cycle after the store edge.

Reset
REQ-031 On reset, all memory words, FIFO pointers, occupancy, store_count, trace_overflow and oor_err SHALL become 0.
REQ-032 During reset, stores SHALL be ignored; m_data_rdata SHALL read 0 after the reset edge.
REQ-033 Reset mid-stream SHALL discard all pending records; trace_valid = 0 in the following cycle.

Structure
REQ-034 Shared package SHALL hold DM_WORDS, TRACE_DEPTH, the byteen encodings (word 1111, half 0011/1100, byte 0001..1000) and the trace-record field widths.
REQ-035 The FIFO SHALL be a sub-module trace_fifo (96-bit entries, push/pop/full/empty/count).

Verification
REQ-036 Scenario 1: reset, then store 0xDEADBEEF to 0x0010 with byteen 1111 and PC 0x3000.
        Response: next cycle rdata@0x10 = 0xDEADBEEF; trace record {0x3000, 0x10, 0xDEADBEEF}; store_count = 1.
REQ-037 Scenario 2: word 0x11223344 at 0x20, then store 0x0000AB00 with byteen 0010.
        Response: rdata = 0x1122AB44; trace_data = 0x1122AB44.
REQ-038 Scenario 3: 9 stores with trace_ready = 0.
        Response: 8 records held; trace_overflow = 1; popping returns the first 8 records in order.
REQ-039 Scenario 4: FIFO full, push and pop on the same edge.
        Response: occupancy stays 8; trace_overflow stays 0; the new record appears last.
REQ-040 Scenario 5: store to 0x3000, byteen 1111.
        Response: memory unchanged; no record; oor_err = 1; rdata@0x3000 = 0.
REQ-041 Scenario 6: reset asserted with 3 records pending.
        Response: next cycle trace_valid = 0, store_count = 0, rdata@0x10 = 0.
